// File: rtl/decode_unit.sv
// decode_unit: program sequencer/decoder; fetches instructions[pc], emits reg writes or begin_* commands, waits for incPc on long commands.
module decode_unit #(
  parameter int N_INSTR = 4096,
  parameter int PC_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instructions [N_INSTR],
  input  logic              instrVld,
  input  logic              incPc,
  output logic              begin_rdn_load,
  output logic              begin_dnn_load,
  output logic              begin_proc,
  output logic [1:0]        reg_sel,
  output logic              reg_wr_en,
  output logic [27:0]       reg_databus,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_DONE, HALTED, ERROR} state_t;
  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ret_q, ret_d;
  logic [3:0]        op;
  logic              exec;
  always_comb begin
    op      = ir_q[31:28];
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    if (instrVld) begin
      state_d = FETCH;
      pc_d    = '0;
      ret_d   = '0;
    end else begin
      case (state_q)
        FETCH: begin
          ir_d    = instructions[pc_q];
          state_d = EXEC;
        end
        EXEC: begin
          if (op <= 4'd3) begin
            pc_d    = pc_q + 1'b1;
            ret_d   = ret_q + 32'd1;
            state_d = FETCH;
          end else if (op <= 4'd6) begin
            state_d = WAIT_DONE;
          end else if (op == 4'd7) begin
            ret_d   = ret_q + 32'd1;
            state_d = HALTED;
          end else if (op == 4'd8) begin
            pc_d    = ir_q[PC_W-1:0];
            ret_d   = ret_q + 32'd1;
            state_d = FETCH;
          end else begin
            state_d = ERROR;
          end
        end
        WAIT_DONE: if (incPc) begin
          pc_d    = pc_q + 1'b1;
          ret_d   = ret_q + 32'd1;
          state_d = FETCH;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end
  // a restart arriving in EXEC pre-empts the instruction being decoded
  assign exec           = (state_q == EXEC) && !instrVld;
  assign reg_wr_en      = exec && (op >= 4'd1) && (op <= 4'd3);
  assign reg_sel        = reg_wr_en ? op[1:0] - 2'd1 : 2'b00;
  assign begin_rdn_load = exec && (op == 4'd4);
  assign begin_dnn_load = exec && (op == 4'd5);
  assign begin_proc     = exec && (op == 4'd6);
  assign reg_databus    = ir_q[27:0];
  assign pc             = pc_q;
  assign halted         = state_q == HALTED;
  assign illegal        = state_q == ERROR;
  assign retired        = ret_q;
endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed scoreboard bench for decode_unit.
module tb_decode_unit;
  logic        clk = 0;
  logic        rst_n, instrVld, incPc;
  logic [31:0] mem [4096];
  logic        begin_rdn_load, begin_dnn_load, begin_proc, reg_wr_en;
  logic [1:0]  reg_sel;
  logic [27:0] reg_databus;
  logic [11:0] pc;
  logic        halted, illegal;
  logic [31:0] retired;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  typedef struct {int kind; logic [1:0] sel; logic [27:0] data; int at;} ev_t;
  ev_t         sb[$];
  ev_t         me;
  int          mk;

  decode_unit dut (
    .clk(clk), .rst_n(rst_n), .instructions(mem), .instrVld(instrVld), .incPc(incPc),
    .begin_rdn_load(begin_rdn_load), .begin_dnn_load(begin_dnn_load), .begin_proc(begin_proc),
    .reg_sel(reg_sel), .reg_wr_en(reg_wr_en), .reg_databus(reg_databus), .pc(pc),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr_en | begin_rdn_load | begin_dnn_load | begin_proc) begin
      mk = reg_wr_en ? 0 : begin_rdn_load ? 1 : begin_dnn_load ? 2 : 3;
      total++;
      if ($countones({reg_wr_en, begin_rdn_load, begin_dnn_load, begin_proc}) != 1) begin
        bad++;
        $display("FAIL onehot cyc=%0d got wr=%0b rdn=%0b dnn=%0b proc=%0b want exactly one",
                 cyc, reg_wr_en, begin_rdn_load, begin_dnn_load, begin_proc);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got kind=%0d data=%0h want none", cyc, mk, reg_databus);
      end else begin
        me = sb.pop_front();
        if (mk != me.kind || reg_databus != me.data || cyc != me.at || (mk == 0 && reg_sel != me.sel)) begin
          bad++;
          $display("FAIL pulse got kind=%0d sel=%0d data=%0h cyc=%0d want kind=%0d sel=%0d data=%0h cyc=%0d",
                   mk, reg_sel, reg_databus, cyc, me.kind, me.sel, me.data, me.at);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(int kind, logic [1:0] sel, logic [27:0] data, int at);
    ev_t e;
    e.kind = kind; e.sel = sel; e.data = data; e.at = at;
    sb.push_back(e);
  endtask

  task automatic start(output int c);
    c = cyc;
    instrVld = 1;
    tick();
    instrVld = 0;
  endtask

  task automatic pulse_inc(output int c);
    c = cyc;
    incPc = 1;
    tick();
    incPc = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, d, e;
    rst_n = 0; instrVld = 0; incPc = 0;
    clear_mem();
    tick(3);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_retired", retired, 0);
    chk("rst_flags", {30'd0, halted, illegal}, 0);
    chk("rst_databus", 32'(reg_databus), 0);
    rst_n = 1;
    tick();

    // register writes then HALT
    mem[0] = 32'h1000_0100; mem[1] = 32'h2000_0003; mem[2] = 32'h3000_2000; mem[3] = 32'h7000_0000;
    c = cyc;
    expect_ev(0, 2'd0, 28'h100, c + 2);
    expect_ev(0, 2'd1, 28'h3, c + 4);
    expect_ev(0, 2'd2, 28'h2000, c + 6);
    start(c);
    wait_to(c + 10);
    chk("t1_halted", 32'(halted), 1);
    chk("t1_retired", retired, 4);
    chk("t1_pc", 32'(pc), 3);

    // LOAD_RDN with long wait
    clear_mem();
    mem[0] = 32'h4000_0400; mem[1] = 32'h2000_0007; mem[2] = 32'h7000_0000;
    c = cyc;
    expect_ev(1, 2'd0, 28'h400, c + 2);
    start(c);
    wait_to(c + 52);
    chk("t2_pc_wait", 32'(pc), 0);
    chk("t2_databus_hold", 32'(reg_databus), 32'h400);
    d = cyc;
    expect_ev(0, 2'd1, 28'h7, d + 2);
    pulse_inc(d);
    chk("t2_pc_after_inc", 32'(pc), 1);
    wait_to(d + 6);
    chk("t2_halted", 32'(halted), 1);
    chk("t2_retired", retired, 3);

    // LOAD_DNN, PROC, HALT with spurious incPc
    clear_mem();
    mem[0] = 32'h5000_0055; mem[1] = 32'h6000_0066; mem[2] = 32'h7000_0000;
    c = cyc;
    expect_ev(2, 2'd0, 28'h55, c + 2);
    instrVld = 1; incPc = 1;
    tick();
    instrVld = 0;
    tick(2);
    incPc = 0;
    wait_to(c + 8);
    chk("t3_pc_spurious", 32'(pc), 0);
    chk("t3_retired_spurious", retired, 0);
    d = cyc;
    expect_ev(3, 2'd0, 28'h66, d + 2);
    pulse_inc(d);
    wait_to(d + 6);
    chk("t3_pc_mid", 32'(pc), 1);
    chk("t3_retired_mid", retired, 1);
    pulse_inc(e);
    wait_to(e + 6);
    chk("t3_halted", 32'(halted), 1);
    chk("t3_retired", retired, 3);

    // illegal opcode at word 5
    clear_mem();
    mem[5] = 32'hF000_0000;
    start(c);
    wait_to(c + 15);
    chk("t4_illegal", 32'(illegal), 1);
    chk("t4_pc", 32'(pc), 5);
    chk("t4_retired", retired, 5);
    pulse_inc(d);
    wait_to(c + 25);
    chk("t4_illegal_sticky", 32'(illegal), 1);
    chk("t4_pc_sticky", 32'(pc), 5);
    mem[0] = 32'h1000_0ABC; mem[1] = 32'h7000_0000;
    d = cyc;
    expect_ev(0, 2'd0, 28'hABC, d + 2);
    start(d);
    chk("t4_illegal_clr", 32'(illegal), 0);
    chk("t4_pc_clr", 32'(pc), 0);
    chk("t4_retired_clr", retired, 0);
    wait_to(d + 6);

    // JMP to the last word, wrap to 0
    clear_mem();
    mem[0] = 32'h8FFF_FFFF;
    start(c);
    wait_to(c + 3);
    chk("t5_pc_4095", 32'(pc), 32'hFFF);
    mem[0] = 32'h7000_0000;
    wait_to(c + 5);
    chk("t5_pc_wrap", 32'(pc), 0);
    wait_to(c + 8);
    chk("t5_halted", 32'(halted), 1);
    chk("t5_retired", retired, 3);

    // reset during WAIT_DONE
    clear_mem();
    mem[0] = 32'h6000_0077;
    c = cyc;
    expect_ev(3, 2'd0, 28'h77, c + 2);
    start(c);
    wait_to(c + 5);
    rst_n = 0;
    tick(2);
    rst_n = 1;
    chk("t6_pc", 32'(pc), 0);
    chk("t6_retired", retired, 0);
    chk("t6_databus", 32'(reg_databus), 0);
    chk("t6_flags", {30'd0, halted, illegal}, 0);
    pulse_inc(d);
    tick(10);
    chk("t6_pc_idle", 32'(pc), 0);
    chk("t6_retired_idle", retired, 0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
